// File: rtl/sd_resp_pkg.sv
// Shared state encoding and sector geometry for the sector-transfer responder.
package sd_resp_pkg;
  localparam int SECTOR_WORDS = 256;
  localparam int BUFF_AW      = 8;
  localparam logic [BUFF_AW-1:0] LAST_IDX = BUFF_AW'(SECTOR_WORDS - 1);

  typedef enum logic [3:0] {
    IDLE, RD_ISSUE, RD_WAIT, RD_PUT, WR_ADDR, WR_LATCH, WR_ISSUE, WR_WAIT, DONE
  } state_t;

  // sd_ack is high exactly while the FSM is inside a word loop.
  function automatic logic in_transfer(state_t s);
    return (s != IDLE) && (s != DONE);
  endfunction
endpackage

// File: rtl/sd_sector_responder.sv
// Target side of the sd_lba/sd_rd/sd_wr/sd_ack sector handshake, moving one
// 256-word sector between the initiator buffer port and a word-addressed memory.
// IDLE accept req | RD_ISSUE mem_rd | RD_WAIT await ready | RD_PUT buffer strobe
// WR_ADDR addr settles | WR_LATCH take din | WR_ISSUE mem_wr | WR_WAIT await ready | DONE gap
module sd_sector_responder
  import sd_resp_pkg::*;
#(
  parameter int LBA_W  = 7,
  parameter int MEM_AW = LBA_W + 8
) (
  input  logic               clk_sys,
  input  logic               RESET_N,
  input  logic [31:0]        sd_lba,
  input  logic               sd_rd,
  input  logic               sd_wr,
  output logic               sd_ack,
  output logic [BUFF_AW-1:0] sd_buff_addr,
  output logic [15:0]        sd_buff_dout,
  output logic               sd_buff_wr,
  input  logic [15:0]        sd_buff_din,
  output logic [MEM_AW-1:0]  mem_addr,
  output logic               mem_rd,
  output logic               mem_wr,
  output logic [15:0]        mem_wdata,
  input  logic [15:0]        mem_rdata,
  input  logic               mem_ready
);
  state_t             state, state_next;
  logic [LBA_W-1:0]   lba_q;
  logic [BUFF_AW-1:0] idx;
  logic               start, idx_inc, rd_capture, wr_latch, last_word;
  logic               unused_lba_hi;

  assign last_word     = (idx == LAST_IDX);
  assign unused_lba_hi = ^sd_lba[31:LBA_W];
  assign sd_buff_addr  = idx;
  assign mem_addr      = {lba_q, idx};

  always_comb begin
    state_next = state;
    start      = 1'b0;
    idx_inc    = 1'b0;
    rd_capture = 1'b0;
    wr_latch   = 1'b0;
    case (state)
      IDLE: begin
        if (sd_rd) begin
          state_next = RD_ISSUE;
          start      = 1'b1;
        end else if (sd_wr) begin
          state_next = WR_ADDR;
          start      = 1'b1;
        end
      end
      RD_ISSUE: state_next = RD_WAIT;
      RD_WAIT: begin
        if (mem_ready) begin
          state_next = RD_PUT;
          rd_capture = 1'b1;
        end
      end
      RD_PUT: begin
        if (last_word) begin
          state_next = DONE;
        end else begin
          state_next = RD_ISSUE;
          idx_inc    = 1'b1;
        end
      end
      WR_ADDR: state_next = WR_LATCH;
      WR_LATCH: begin
        state_next = WR_ISSUE;
        wr_latch   = 1'b1;
      end
      WR_ISSUE: state_next = WR_WAIT;
      WR_WAIT: begin
        if (mem_ready) begin
          if (last_word) begin
            state_next = DONE;
          end else begin
            state_next = WR_ADDR;
            idx_inc    = 1'b1;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they are registered yet
  // coincide with the state they belong to.
  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      state        <= IDLE;
      lba_q        <= '0;
      idx          <= '0;
      sd_ack       <= 1'b0;
      sd_buff_dout <= '0;
      sd_buff_wr   <= 1'b0;
      mem_rd       <= 1'b0;
      mem_wr       <= 1'b0;
      mem_wdata    <= '0;
    end else begin
      state      <= state_next;
      sd_ack     <= in_transfer(state_next);
      sd_buff_wr <= (state_next == RD_PUT);
      mem_rd     <= (state_next == RD_ISSUE);
      mem_wr     <= (state_next == WR_ISSUE);
      if (start) begin
        lba_q <= sd_lba[LBA_W-1:0];
        idx   <= '0;
      end else if (idx_inc) begin
        idx <= idx + 1'b1;
      end
      if (rd_capture) sd_buff_dout <= mem_rdata;
      if (wr_latch)   mem_wdata    <= sd_buff_din;
    end
  end
endmodule

// File: tb/tb_sd_sector_responder.sv
// Bench for sd_sector_responder: directed and randomized sectors against an
// array-based reference of backing memory and per-sector cost arithmetic.
module tb_sd_sector_responder;
  localparam int MEM_AW = 15;
  localparam int NW     = 1 << MEM_AW;

  logic              clk_sys = 1'b0;
  logic              RESET_N = 1'b0;
  logic [31:0]       sd_lba = '0;
  logic              sd_rd = 1'b0;
  logic              sd_wr = 1'b0;
  logic              sd_ack;
  logic [7:0]        sd_buff_addr;
  logic [15:0]       sd_buff_dout;
  logic              sd_buff_wr;
  logic [15:0]       sd_buff_din = '0;
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_rd, mem_wr;
  logic [15:0]       mem_wdata;
  logic [15:0]       mem_rdata = '0;
  logic              mem_ready = 1'b0;

  sd_sector_responder dut (
    .clk_sys(clk_sys), .RESET_N(RESET_N), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
    .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  always #5 clk_sys = ~clk_sys;

  logic [15:0] mem     [NW];
  logic [15:0] ref_mem [NW];
  logic [15:0] buff    [256];
  logic [15:0] got     [256];

  int checks = 0, failures = 0;
  int lat = 1;
  bit spur_en = 1'b0;

  // Backing memory with latency lat; optional spurious ready while idle.
  bit mem_init = 1'b0, m_busy = 1'b0, m_wr = 1'b0;
  int m_cnt = 0;
  logic [MEM_AW-1:0] m_addr = '0;
  always @(posedge clk_sys) begin
    if (!mem_init) begin
      for (int a = 0; a < NW; a++) mem[a] = 16'(a[7:0]) ^ 16'hA5A5;
      mem_init = 1'b1;
    end
    mem_ready <= 1'b0;
    if (!RESET_N) begin
      m_busy = 1'b0;
    end else begin
      if (!m_busy && (mem_rd || mem_wr)) begin
        m_busy = 1'b1; m_wr = mem_wr; m_addr = mem_addr; m_cnt = lat;
      end
      if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_busy = 1'b0;
          mem_ready <= 1'b1;
          if (m_wr) mem[m_addr] = mem_wdata;
          else mem_rdata <= mem[m_addr];
        end
      end else if (spur_en && !sd_ack && $urandom_range(0, 3) == 0) begin
        mem_ready <= 1'b1;
        mem_rdata <= 16'($urandom);
      end
    end
  end

  // Initiator buffer: read data valid one cycle after the address.
  always @(posedge clk_sys) sd_buff_din <= buff[sd_buff_addr];

  int ack_cycles = 0, wr_pulses = 0, put_cnt = 0, order_err = 0, follow_err = 0;
  int min_gap = 1000, low_run = 0, put_idx = 0;
  bit prev_ack = 1'b0, prev_rdy = 1'b0, seen_fall = 1'b0;
  logic [MEM_AW-1:0] last_wr_addr = '0;
  always @(posedge clk_sys) begin
    if (sd_ack && !prev_ack) begin
      put_idx = 0;
      if (seen_fall && low_run < min_gap) min_gap = low_run;
    end
    if (!sd_ack && prev_ack) seen_fall = 1'b1;
    if (sd_ack) begin ack_cycles++; low_run = 0; end
    else low_run++;
    if (mem_wr) begin wr_pulses++; last_wr_addr = mem_addr; end
    if (sd_buff_wr) begin
      if (sd_buff_addr != put_idx[7:0]) order_err++;
      if (!prev_rdy) follow_err++;
      got[sd_buff_addr] = sd_buff_dout;
      put_idx++;
      put_cnt++;
    end
    prev_ack = sd_ack;
    prev_rdy = mem_ready;
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic outs_zero(input string tag);
    chk(tag, longint'({sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr, mem_addr,
                       mem_rd, mem_wr, mem_wdata}), 0);
  endtask

  task automatic wait_ack_rise();
    int n = 0;
    while (!sd_ack && n < 8) begin @(posedge clk_sys); #1; n++; end
    sd_rd = 1'b0; sd_wr = 1'b0; sd_lba = $urandom;
    chk("ack_rise", longint'(sd_ack), 1);
  endtask

  // One full sector; expectations come from the reference image and cost formulas.
  task automatic sector(input bit rd, input bit wr, input logic [31:0] lba);
    int n, mism, a0, w0, p0, o0, f0;
    logic [6:0] l7;
    l7 = lba[6:0];
    a0 = ack_cycles; w0 = wr_pulses; p0 = put_cnt; o0 = order_err; f0 = follow_err;
    sd_lba = lba; sd_rd = rd; sd_wr = wr;
    wait_ack_rise();
    n = 0;
    while (sd_ack && n < 4000) begin @(posedge clk_sys); #1; n++; end
    chk("ack_fall", longint'(sd_ack), 0);
    mism = 0;
    if (rd) begin
      for (int i = 0; i < 256; i++) if (got[i] !== ref_mem[{l7, i[7:0]}]) mism++;
      chk("rd_ack_cycles", ack_cycles - a0, 256 * (2 + lat));
      chk("rd_strobes", put_cnt - p0, 256);
      chk("rd_no_mem_wr", wr_pulses - w0, 0);
      chk("rd_order", order_err - o0, 0);
      chk("rd_follow_ready", follow_err - f0, 0);
      chk("rd_data", mism, 0);
    end else begin
      for (int i = 0; i < 256; i++) ref_mem[{l7, i[7:0]}] = buff[i];
      for (int i = 0; i < 256; i++) if (mem[{l7, i[7:0]}] !== ref_mem[{l7, i[7:0]}]) mism++;
      chk("wr_ack_cycles", ack_cycles - a0, 256 * (3 + lat));
      chk("wr_pulses", wr_pulses - w0, 256);
      chk("wr_no_strobe", put_cnt - p0, 0);
      chk("wr_last_addr", longint'(last_wr_addr), longint'({l7, 8'hFF}));
      chk("wr_data", mism, 0);
    end
  endtask

  initial begin
    int n, p0, op, mism;
    for (int a = 0; a < NW; a++) ref_mem[a] = 16'(a[7:0]) ^ 16'hA5A5;
    for (int i = 0; i < 256; i++) buff[i] = '0;
    repeat (3) @(posedge clk_sys);
    #1;
    outs_zero("reset_outputs");
    RESET_N = 1'b1;
    @(posedge clk_sys); #1;

    lat = 1;
    sector(1'b1, 1'b0, 32'd3);

    for (int i = 0; i < 256; i++) buff[i] = 16'h1000 + 16'(i);
    sector(1'b0, 1'b1, 32'd127);

    sector(1'b1, 1'b1, 32'hFFFF_FF85);

    // Back-to-back writes, each request raised as soon as sd_ack falls.
    for (int s = 0; s < 8; s++) begin
      for (int i = 0; i < 256; i++) buff[i] = 16'($urandom);
      sector(1'b0, 1'b1, {$urandom_range(0, 1023), 7'(16 + s)} );
    end
    chk("gap_at_least_1", longint'(min_gap >= 1), 1);

    // Reset in the middle of a read, then a clean read must restart at word 0.
    lat = 2;
    sd_lba = 32'd3; sd_rd = 1'b1;
    wait_ack_rise();
    p0 = put_cnt; n = 0;
    while (put_cnt - p0 < 100 && n < 2000) begin @(posedge clk_sys); #1; n++; end
    chk("reached_word_100", put_cnt - p0, 100);
    #2 RESET_N = 1'b0;
    #1 outs_zero("async_reset_outputs");
    @(negedge clk_sys); @(negedge clk_sys);
    RESET_N = 1'b1;
    @(posedge clk_sys); #1;
    lat = 1;
    sector(1'b1, 1'b0, 32'd127);

    // Random ops, latencies and LBAs, with idle-time spurious mem_ready.
    spur_en = 1'b1;
    for (int s = 0; s < 12; s++) begin
      op  = $urandom_range(0, 2);
      lat = $urandom_range(1, 8);
      if (op == 1) for (int i = 0; i < 256; i++) buff[i] = 16'($urandom);
      repeat ($urandom_range(0, 5)) begin @(posedge clk_sys); #1; end
      sector(op != 1, op != 0, $urandom);
    end
    spur_en = 1'b0;

    mism = 0;
    for (int a = 0; a < NW; a++) if (mem[a] !== ref_mem[a]) mism++;
    chk("final_memory_image", mism, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sd_sector_responder.md
# sd_sector_responder

Target side of the sector-transfer handshake (`sd_lba` / `sd_rd` / `sd_wr` / `sd_ack` / `sd_buff_*`) that the backup-RAM save/load logic drives as initiator. It accepts one 512-byte sector request at a time and moves 256 16-bit words between the initiator's buffer port and a word-addressed backing memory. It is used as local backup storage and as the HPS-side model in core benches.

## Interface
Parameters:
- `LBA_W`, 7: low `sd_lba` bits used for memory addressing.
- `MEM_AW`, `LBA_W+8`: backing-memory word-address width.

Ports:
- `clk_sys` in 1: single clock, all logic on the rising edge.
- `RESET_N` in 1: asynchronous, active-low reset.
- `sd_lba` in 32: sector number, latched when a request is accepted.
- `sd_rd` in 1: level request for a read (memory → buffer).
- `sd_wr` in 1: level request for a write (buffer → memory).
- `sd_ack` out 1: high for the whole sector transfer.
- `sd_buff_addr` out 8: word index into the initiator buffer.
- `sd_buff_dout` out 16: read data toward the initiator.
- `sd_buff_wr` out 1: 1-cycle strobe; `sd_buff_dout` is valid at `sd_buff_addr` during the strobe.
- `sd_buff_din` in 16: initiator buffer data; valid 1 cycle after `sd_buff_addr` changes.
- `mem_addr` out MEM_AW: `{lba_q[LBA_W-1:0], idx}`.
- `mem_rd` out 1, `mem_wr` out 1: 1-cycle request pulses.
- `mem_wdata` out 16: write data, stable from the `mem_wr` pulse until `mem_ready`.
- `mem_rdata` in 16: read data, valid with `mem_ready`.
- `mem_ready` in 1: 1-cycle completion pulse, at least 1 cycle after the request.

## Operation
- States: IDLE, RD_ISSUE, RD_WAIT, RD_PUT, WR_ADDR, WR_LATCH, WR_ISSUE, WR_WAIT, DONE.
- IDLE:
  - `sd_rd` high → latch `sd_lba` into `lba_q`, set `idx=0`, set `sd_ack=1`, go to RD_ISSUE.
  - Otherwise `sd_wr` high → same latching, go to WR_ADDR.
  - Both high → read wins.
- Read loop:
  - RD_ISSUE: pulse `mem_rd`.
  - RD_WAIT: hold until `mem_ready`, then capture `mem_rdata` into `sd_buff_dout`.
  - RD_PUT: `sd_buff_wr=1`. If `idx==255` go to DONE, else `idx++` and go to RD_ISSUE.
- Write loop:
  - WR_ADDR: `sd_buff_addr=idx` settles.
  - WR_LATCH: `mem_wdata <= sd_buff_din`.
  - WR_ISSUE: pulse `mem_wr`.
  - WR_WAIT: hold until `mem_ready`. If `idx==255` go to DONE, else `idx++` and go to WR_ADDR.
- `sd_buff_addr` always equals `idx`; `idx` is 8 bits and never wraps (terminal value 255 ends the sector).
- DONE: `sd_ack<=0`, go to IDLE. IDLE accepts no request in the cycle `sd_ack` falls, so `sd_ack` is low for at least 1 cycle between sectors.
- Initiator drops its request on the rising edge of `sd_ack`. Request levels during a transfer are ignored. A request still high in IDLE after that 1-cycle gap starts a new sector.
- `sd_lba` changes after acceptance are ignored; bits above `LBA_W` are ignored.
- `mem_ready` outside the WAIT states is ignored.
- Reset, asserted at any time:
  - state → IDLE; every output → 0 (`sd_ack`, `sd_buff_addr`, `sd_buff_dout`, `sd_buff_wr`, `mem_addr`, `mem_rd`, `mem_wr`, `mem_wdata`).
  - Any in-flight memory transaction is abandoned; the memory side tolerates this.

## Timing
- Request sampled at edge N → `sd_ack` high after edge N; first `mem_rd` or WR_ADDR state in cycle N+1.
- Per-word cost, with memory latency L (≥1):
  - Read: 2+L cycles; with L=1, 768 cycles per sector.
  - Write: 3+L cycles; with L=1, 1024 cycles per sector.
- `sd_buff_wr` follows `mem_ready` by exactly 1 cycle.
- `sd_ack` falls 1 cycle after the last `sd_buff_wr` (read) or the last `mem_ready` (write).
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Shared package `sd_resp_pkg` holds:
  - the state enum;
  - `SECTOR_WORDS=256`;
  - `BUFF_AW=8`.
- Single module, no sub-module. Word counter and FSM are inline.

## Test plan
- Read, memory preloaded with `mem[{lba,i}]=i^16'hA5A5`, `sd_lba=3`, L=1 → 256 `sd_buff_wr` strobes with `addr=i`, `data=i^A5A5`; `sd_ack` high exactly 768 cycles.
- Write, buffer holds `16'h1000+i`, `sd_lba=127` → `mem[{127,i}]=1000+i` for all i; `mem_addr` reaches 0x7FFF last; `sd_ack` high exactly 1024 cycles.
- Full 128-sector save sequence driven like the backup-RAM initiator (next request on falling `sd_ack`) → all 32768 words correct; `sd_ack` low ≥1 cycle between sectors.
- `sd_rd` and `sd_wr` high simultaneously → read performed; no `mem_wr` pulse.
- `RESET_N` low at word 100 of a read → all outputs 0 asynchronously; next read restarts at `idx=0`.
- Random L in 1..8 with `mem_ready` pulses injected in IDLE → data intact; spurious `mem_ready` pulses have no effect.
